// File: rtl/sys_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : sys_bridge
//  Purpose  : Data-side system bridge behind the CPU Memory stage. It decodes
//             the data bus to the external DM, the timer/counters and the
//             interrupt-ack register. It also generates byte lanes, extends
//             load data and detects AdEL/AdES.
//  Options  : SYS_BRIDGE_TC1_EN - when defined, the second timer (TC1) is
//             built at 0x7F10-0x7F1B. When undefined, that window is unmapped
//             and tc_irq[1] is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module sys_bridge #(
    parameter logic [31:0] DM_TOP   = 32'h0000_2FFF,
    parameter int          TC_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic        m_data_mem_write,
    input  logic [2:0]  m_data_sel,
    input  logic        m_data_req,
    output logic [31:0] m_data_rdata,
    output logic [4:0]  m_data_exc,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_byteen,
    input  logic [31:0] dm_rdata,
    output logic [1:0]  tc_irq
);

`ifdef SYS_BRIDGE_TC1_EN
    localparam int NUM_TC = 2;
`else
    localparam int NUM_TC = 1;
`endif

    localparam logic [31:0] TC_BASE   = 32'h0000_7F00;
    localparam logic [31:0] IACK_BASE = 32'h0000_7F20;
    localparam logic [31:0] IACK_LAST = 32'h0000_7F23;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam logic [2:0] SEL_WORD = 3'd1;
    localparam logic [2:0] SEL_LH   = 3'd2;
    localparam logic [2:0] SEL_LHU  = 3'd3;
    localparam logic [2:0] SEL_LB   = 3'd4;
    localparam logic [2:0] SEL_LBU  = 3'd5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

    localparam logic [TC_WIDTH-1:0] C_ONE = TC_WIDTH'(1);

    // ------------------------------------------------------------------
    // Access classification and address decode
    // ------------------------------------------------------------------
    logic w_is_word, w_is_half, w_is_byte, w_acc;
    logic w_dm_hit, w_iack_hit, w_any_tc_hit, w_count_hit, w_mapped;
    logic w_exc, w_wr_ok, w_iack_we;

    logic [NUM_TC-1:0]   w_tc_hit;
    logic [NUM_TC-1:0]   w_tc_we;
    logic [NUM_TC-1:0]   w_tc_ack;
    logic [NUM_TC-1:0]   w_tc_irq;
    logic [3:0]          w_tc_ctrl   [NUM_TC];
    logic [TC_WIDTH-1:0] w_tc_preset [NUM_TC];
    logic [TC_WIDTH-1:0] w_tc_count  [NUM_TC];

    assign w_is_word = (m_data_sel == SEL_WORD);
    assign w_is_half = (m_data_sel == SEL_LH) || (m_data_sel == SEL_LHU);
    assign w_is_byte = (m_data_sel == SEL_LB) || (m_data_sel == SEL_LBU);
    // Codes 6/7 behave exactly like "no access".
    assign w_acc     = w_is_word || w_is_half || w_is_byte;

    assign w_dm_hit     = (m_data_addr <= DM_TOP);
    assign w_iack_hit   = (m_data_addr >= IACK_BASE) && (m_data_addr <= IACK_LAST);
    assign w_any_tc_hit = |w_tc_hit;
    assign w_count_hit  = w_any_tc_hit && (m_data_addr[3:2] == 2'd2);
    assign w_mapped     = w_dm_hit || w_any_tc_hit || w_iack_hit;

    // Alignment, map holes, sub-word peripheral access and COUNT stores all fault.
    assign w_exc = w_acc && (
                       (w_is_word && (m_data_addr[1:0] != 2'b00)) ||
                       (w_is_half && m_data_addr[0])              ||
                       !w_mapped                                  ||
                       ((w_is_half || w_is_byte) && (w_any_tc_hit || w_iack_hit)) ||
                       (m_data_mem_write && w_count_hit));

    assign m_data_exc = w_exc ? (m_data_mem_write ? EXC_ADES : EXC_ADEL) : EXC_NONE;

    // A write reaches any target only for a clean, unsquashed store.
    assign w_wr_ok   = w_acc && !w_exc && !m_data_req && m_data_mem_write;
    assign w_iack_we = w_wr_ok && w_iack_hit;

    // ------------------------------------------------------------------
    // DM store path
    // ------------------------------------------------------------------
    logic [3:0] w_lane_be;

    assign dm_addr = {m_data_addr[31:2], 2'b00};

    // Replicate store data across lanes and pick the byte enables.
    always_comb begin
        w_lane_be = 4'b0000;
        dm_wdata  = m_data_wdata;
        if (w_is_word) begin
            w_lane_be = 4'b1111;
        end else if (w_is_half) begin
            w_lane_be = 4'b0011 << m_data_addr[1:0];
            dm_wdata  = {2{m_data_wdata[15:0]}};
        end else if (w_is_byte) begin
            w_lane_be = 4'b0001 << m_data_addr[1:0];
            dm_wdata  = {4{m_data_wdata[7:0]}};
        end
    end

    assign dm_byteen = (w_wr_ok && w_dm_hit) ? w_lane_be : 4'b0000;

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    logic [31:0] w_tc_rdata;
    logic [31:0] w_src;
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Register read mux for whichever timer window is addressed.
    always_comb begin
        w_tc_rdata = 32'd0;
        for (int i = 0; i < NUM_TC; i++) begin
            if (w_tc_hit[i]) begin
                case (m_data_addr[3:2])
                    2'd0:    w_tc_rdata = {28'd0, w_tc_ctrl[i]};
                    2'd1:    w_tc_rdata = 32'(w_tc_preset[i]);
                    2'd2:    w_tc_rdata = 32'(w_tc_count[i]);
                    default: w_tc_rdata = 32'd0;
                endcase
            end
        end
    end

    // IACK is write-only, so it falls through to zero here.
    assign w_src  = w_dm_hit ? dm_rdata : w_tc_rdata;
    assign w_half = m_data_addr[1] ? w_src[31:16] : w_src[15:0];

    // Pick the addressed byte lane.
    always_comb begin
        case (m_data_addr[1:0])
            2'd0:    w_byte = w_src[7:0];
            2'd1:    w_byte = w_src[15:8];
            2'd2:    w_byte = w_src[23:16];
            default: w_byte = w_src[31:24];
        endcase
    end

    // Extend the selected field; faulting or absent accesses return zero.
    always_comb begin
        m_data_rdata = 32'd0;
        if (w_acc && !w_exc) begin
            case (m_data_sel)
                SEL_WORD: m_data_rdata = w_src;
                SEL_LH:   m_data_rdata = {{16{w_half[15]}}, w_half};
                SEL_LHU:  m_data_rdata = {16'd0, w_half};
                SEL_LB:   m_data_rdata = {{24{w_byte[7]}}, w_byte};
                SEL_LBU:  m_data_rdata = {24'd0, w_byte};
                default:  m_data_rdata = 32'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Timer/counters: one instance per 16-byte window starting at TC_BASE
    // ------------------------------------------------------------------
    for (genvar n = 0; n < NUM_TC; n++) begin : g_tc
        localparam logic [31:0] C_BASE = TC_BASE + (32'(n) << 4);

        logic [1:0]          state_q, state_d;
        logic [3:0]          ctrl_q, ctrl_d;
        logic [TC_WIDTH-1:0] preset_q, preset_d;
        logic [TC_WIDTH-1:0] count_q, count_d;
        logic                flag_q, flag_d;
        logic                irq_q;
        logic                w_ctrl_we, w_preset_we, w_en, w_auto;

        assign w_tc_hit[n] = (m_data_addr >= C_BASE) &&
                             (m_data_addr <= C_BASE + 32'h0000_000B);
        assign w_tc_we[n]  = w_wr_ok && w_tc_hit[n];
        assign w_tc_ack[n] = w_iack_we && m_data_wdata[n];

        assign w_ctrl_we   = w_tc_we[n] && (m_data_addr[3:2] == 2'd0);
        assign w_preset_we = w_tc_we[n] && (m_data_addr[3:2] == 2'd1);
        // A CTRL write in this cycle overrides the stored enable.
        assign w_en        = w_ctrl_we ? m_data_wdata[0] : ctrl_q[0];
        assign w_auto      = (ctrl_q[2:1] == 2'b01);

        // State register.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= S_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // Next-state logic.
        always_comb begin
            state_d = state_q;
            case (state_q)
                S_IDLE: if (w_en) state_d = S_LOAD;
                S_LOAD: state_d = S_CNT;
                S_CNT: begin
                    if (!w_en) begin
                        state_d = S_IDLE;
                    end else if (count_q <= C_ONE) begin
                        state_d = S_INT;
                    end
                end
                S_INT:   state_d = w_auto ? S_LOAD : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // Register updates per state; bus writes are applied last so they win.
        always_comb begin
            ctrl_d   = ctrl_q;
            preset_d = preset_q;
            count_d  = count_q;
            flag_d   = w_auto ? 1'b0 : flag_q;
            case (state_q)
                S_LOAD: count_d = preset_q;
                S_CNT: begin
                    if (w_en) begin
                        count_d = (count_q > C_ONE) ? (count_q - C_ONE) : '0;
                    end
                end
                S_INT: begin
                    flag_d = 1'b1;
                    if (!w_auto) begin
                        ctrl_d[0] = 1'b0;
                    end
                end
                default: ;
            endcase
            if (w_ctrl_we) begin
                ctrl_d = m_data_wdata[3:0];
                flag_d = 1'b0;
            end
            if (w_preset_we) begin
                preset_d = m_data_wdata[TC_WIDTH-1:0];
            end
            if (w_tc_ack[n]) begin
                flag_d = 1'b0;
            end
        end

        // Timer registers and the registered interrupt line.
        always_ff @(posedge clk) begin
            if (reset) begin
                ctrl_q   <= 4'd0;
                preset_q <= '0;
                count_q  <= '0;
                flag_q   <= 1'b0;
                irq_q    <= 1'b0;
            end else begin
                ctrl_q   <= ctrl_d;
                preset_q <= preset_d;
                count_q  <= count_d;
                flag_q   <= flag_d;
                irq_q    <= flag_d & ctrl_d[3];
            end
        end

        assign w_tc_ctrl[n]   = ctrl_q;
        assign w_tc_preset[n] = preset_q;
        assign w_tc_count[n]  = count_q;
        assign w_tc_irq[n]    = irq_q;
    end

    assign tc_irq[0] = w_tc_irq[0];
`ifdef SYS_BRIDGE_TC1_EN
    assign tc_irq[1] = w_tc_irq[1];
`else
    assign tc_irq[1] = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sys_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sys_bridge
//  Purpose  : Self-checking bench for sys_bridge. It applies table-driven
//             combinational vectors, then directed timer sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sys_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic        m_data_mem_write;
    logic [2:0]  m_data_sel;
    logic        m_data_req;
    logic [31:0] m_data_rdata;
    logic [4:0]  m_data_exc;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_byteen;
    logic [31:0] dm_rdata;
    logic [1:0]  tc_irq;

    sys_bridge dut (
        .clk              (clk),
        .reset            (reset),
        .m_data_addr      (m_data_addr),
        .m_data_wdata     (m_data_wdata),
        .m_data_mem_write (m_data_mem_write),
        .m_data_sel       (m_data_sel),
        .m_data_req       (m_data_req),
        .m_data_rdata     (m_data_rdata),
        .m_data_exc       (m_data_exc),
        .dm_addr          (dm_addr),
        .dm_wdata         (dm_wdata),
        .dm_byteen        (dm_byteen),
        .dm_rdata         (dm_rdata),
        .tc_irq           (tc_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic        we;
        logic        req;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] dmr;
        logic [31:0] e_rdata;
        logic [4:0]  e_exc;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] sel, input logic we, input logic req,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] dmr, input logic [31:0] e_rdata,
                       input logic [4:0] e_exc, input logic [3:0] e_be,
                       input logic [31:0] e_wd);
        vec_t v;
        v.sel = sel; v.we = we; v.req = req; v.addr = addr; v.wdata = wdata;
        v.dmr = dmr; v.e_rdata = e_rdata; v.e_exc = e_exc; v.e_be = e_be; v.e_wd = e_wd;
        vq.push_back(v);
    endtask

    task automatic drive(input logic [2:0] sel, input logic we, input logic req,
                         input logic [31:0] addr, input logic [31:0] wdata);
        m_data_sel       = sel;
        m_data_mem_write = we;
        m_data_req       = req;
        m_data_addr      = addr;
        m_data_wdata     = wdata;
    endtask

    task automatic idle();
        drive(3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        drive(3'd1, 1'b1, 1'b0, addr, data);
        tick();
        idle();
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] v);
        drive(3'd1, 1'b0, 1'b0, addr, 32'd0);
        #1;
        v = m_data_rdata;
        idle();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        reset    = 1'b1;
        dm_rdata = 32'd0;
        idle();

        // ---------------- combinational vector table ----------------
        //   sel  we    req   addr           wdata          dm_rdata       rdata          exc   be       dm_wdata
        add(3'd5, 1'b0, 1'b0, 32'h0000_0003, 32'h0,         32'h80FF_1234, 32'h0000_0080, 5'd0, 4'b0000, 32'h0);
        add(3'd4, 1'b0, 1'b0, 32'h0000_0003, 32'h0,         32'h80FF_1234, 32'hFFFF_FF80, 5'd0, 4'b0000, 32'h0);
        add(3'd3, 1'b0, 1'b0, 32'h0000_0002, 32'h0,         32'h80FF_1234, 32'h0000_80FF, 5'd0, 4'b0000, 32'h0);
        add(3'd2, 1'b0, 1'b0, 32'h0000_0002, 32'h0,         32'h80FF_1234, 32'hFFFF_80FF, 5'd0, 4'b0000, 32'h0);
        add(3'd2, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h80FF_1234, 32'h0000_1234, 5'd0, 4'b0000, 32'h0);
        add(3'd1, 1'b0, 1'b0, 32'h0000_0004, 32'h0,         32'h80FF_1234, 32'h80FF_1234, 5'd0, 4'b0000, 32'h0);
        add(3'd4, 1'b0, 1'b0, 32'h0000_0001, 32'h0,         32'h80FF_1234, 32'h0000_0012, 5'd0, 4'b0000, 32'h0);
        add(3'd2, 1'b1, 1'b0, 32'h0000_0006, 32'h0000_ABCD, 32'h0,         32'h0,         5'd0, 4'b1100, 32'hABCD_ABCD);
        add(3'd2, 1'b1, 1'b1, 32'h0000_0006, 32'h0000_ABCD, 32'h0,         32'h0,         5'd0, 4'b0000, 32'hABCD_ABCD);
        add(3'd4, 1'b1, 1'b0, 32'h0000_2FFD, 32'h0000_0057, 32'h0,         32'h0,         5'd0, 4'b0010, 32'h5757_5757);
        add(3'd1, 1'b1, 1'b0, 32'h0000_0010, 32'h1234_5678, 32'h0,         32'h0,         5'd0, 4'b1111, 32'h1234_5678);
        add(3'd1, 1'b0, 1'b0, 32'h0000_0002, 32'h0,         32'h80FF_1234, 32'h0,         5'd4, 4'b0000, 32'h0);
        add(3'd1, 1'b1, 1'b0, 32'h0000_7F08, 32'h0000_0055, 32'h0,         32'h0,         5'd5, 4'b0000, 32'h0000_0055);
        add(3'd1, 1'b0, 1'b0, 32'h0000_7F08, 32'h0,         32'h0,         32'h0,         5'd0, 4'b0000, 32'h0);
        add(3'd4, 1'b0, 1'b0, 32'h0000_7F00, 32'h0,         32'h0,         32'h0,         5'd4, 4'b0000, 32'h0);
        add(3'd1, 1'b0, 1'b0, 32'h0000_3000, 32'h0,         32'h1111_1111, 32'h0,         5'd4, 4'b0000, 32'h0);
        add(3'd2, 1'b1, 1'b0, 32'h0000_0001, 32'h0000_0001, 32'h0,         32'h0,         5'd5, 4'b0000, 32'h0001_0001);
        add(3'd0, 1'b1, 1'b0, 32'h0000_0003, 32'h0,         32'h80FF_1234, 32'h0,         5'd0, 4'b0000, 32'h0);
        add(3'd6, 1'b0, 1'b0, 32'h0000_0002, 32'h0,         32'h80FF_1234, 32'h0,         5'd0, 4'b0000, 32'h0);
        add(3'd1, 1'b0, 1'b0, 32'h0000_7F20, 32'h0,         32'h0,         32'h0,         5'd0, 4'b0000, 32'h0);
        add(3'd1, 1'b1, 1'b0, 32'h0000_7F0C, 32'h0,         32'h0,         32'h0,         5'd5, 4'b0000, 32'h0);
`ifdef SYS_BRIDGE_TC1_EN
        add(3'd1, 1'b0, 1'b0, 32'h0000_7F14, 32'h0,         32'h0,         32'h0,         5'd0, 4'b0000, 32'h0);
`else
        add(3'd1, 1'b0, 1'b0, 32'h0000_7F14, 32'h0,         32'h0,         32'h0,         5'd4, 4'b0000, 32'h0);
`endif
        add(3'd1, 1'b0, 1'b0, 32'h0000_7F00, 32'h0,         32'h0,         32'h0,         5'd0, 4'b0000, 32'h0);
        add(3'd4, 1'b1, 1'b0, 32'h0000_7F03, 32'h0,         32'h0,         32'h0,         5'd5, 4'b0000, 32'h0);
        add(3'd1, 1'b0, 1'b0, 32'h0000_2FFC, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd0, 4'b0000, 32'h0);
        add(3'd4, 1'b0, 1'b0, 32'h0000_2FFF, 32'h0,         32'h7F00_0000, 32'h0000_007F, 5'd0, 4'b0000, 32'h0);

        repeat (2) tick();
        check("reset_irq", {30'd0, tc_irq}, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].sel, vq[i].we, vq[i].req, vq[i].addr, vq[i].wdata);
            dm_rdata = vq[i].dmr;
            #1;
            check($sformatf("v%0d_rdata", i), m_data_rdata, vq[i].e_rdata);
            check($sformatf("v%0d_exc", i), {27'd0, m_data_exc}, {27'd0, vq[i].e_exc});
            check($sformatf("v%0d_byteen", i), {28'd0, dm_byteen}, {28'd0, vq[i].e_be});
            check($sformatf("v%0d_wdata", i), dm_wdata, vq[i].e_wd);
            check($sformatf("v%0d_addr", i), dm_addr, vq[i].addr & 32'hFFFF_FFFC);
            tick();
            idle();
        end
        dm_rdata = 32'd0;

        // ---------------- TC0 one-shot, store to COUNT, IACK ----------------
        bus_write(32'h7F04, 32'd3);
        bus_write(32'h7F00, 32'h9);
        for (int k = 0; k < 4; k++) begin
            tick();
            bus_read(32'h7F08, rd);
            check($sformatf("os_count%0d", k), rd, 32'(3 - k));
            check($sformatf("os_irq%0d", k), {30'd0, tc_irq}, 32'd0);
            if (k == 1) begin
                drive(3'd1, 1'b1, 1'b0, 32'h7F08, 32'hFF);
                #1;
                check("count_store_exc", {27'd0, m_data_exc}, 32'd5);
            end
        end
        tick();
        check("os_irq_set", {30'd0, tc_irq}, 32'd1);
        bus_read(32'h7F00, rd);
        check("os_ctrl", rd, 32'h8);
        tick();
        check("os_irq_held", {30'd0, tc_irq}, 32'd1);
        bus_read(32'h7F08, rd);
        check("os_count_end", rd, 32'd0);
        bus_write(32'h7F20, 32'h1);
        check("os_iack", {30'd0, tc_irq}, 32'd0);

        // ---------------- TC0 PRESET = 0 latency ----------------
        pulse_reset();
        bus_write(32'h7F00, 32'h9);
        tick();
        check("p0_irq_w1", {30'd0, tc_irq}, 32'd0);
        tick();
        check("p0_irq_w2", {30'd0, tc_irq}, 32'd0);
        tick();
        check("p0_irq_w3", {30'd0, tc_irq}, 32'd1);

        // ---------------- TC0 auto-reload, then reset mid-count ----------------
        pulse_reset();
        bus_write(32'h7F04, 32'd2);
        bus_write(32'h7F00, 32'hB);
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("ar_irq%0d", k), {30'd0, tc_irq}, (k % 4 == 0) ? 32'd1 : 32'd0);
            bus_read(32'h7F08, rd);
            check($sformatf("ar_count%0d", k), rd,
                  (k % 4 == 1) ? 32'd2 : ((k % 4 == 2) ? 32'd1 : 32'd0));
        end
        bus_read(32'h7F00, rd);
        check("ar_ctrl", rd, 32'hB);
        tick();
        bus_read(32'h7F08, rd);
        check("ar_count_mid", rd, 32'd2);
        reset = 1'b1;
        tick();
        bus_read(32'h7F08, rd);
        check("rst_count", rd, 32'd0);
        check("rst_irq", {30'd0, tc_irq}, 32'd0);
        bus_read(32'h7F00, rd);
        check("rst_ctrl", rd, 32'd0);
        reset = 1'b0;
        tick();
        tick();
        bus_read(32'h7F08, rd);
        check("rst_idle_count", rd, 32'd0);
        check("rst_idle_irq", {30'd0, tc_irq}, 32'd0);

`ifdef SYS_BRIDGE_TC1_EN
        // ---------------- TC1 auto-reload ----------------
        pulse_reset();
        bus_write(32'h7F14, 32'd2);
        bus_write(32'h7F10, 32'hB);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("tc1_irq%0d", k), {30'd0, tc_irq}, (k % 4 == 0) ? 32'd2 : 32'd0);
        end
`else
        // ---------------- TC1 window unmapped ----------------
        pulse_reset();
        drive(3'd1, 1'b1, 1'b0, 32'h7F10, 32'hB);
        #1;
        check("tc1_off_exc", {27'd0, m_data_exc}, 32'd5);
        tick();
        idle();
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("tc1_off_irq%0d", k), {30'd0, tc_irq}, 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
